// File: rtl/periph_bus_arbiter_pkg.sv
// Shared peripheral-bus definitions: arbiter state encodings, default bus widths, master ids
// and the round-robin pick function used by periph_bus_arbiter.
package periph_bus_arbiter_pkg;

    localparam int PERIPH_AW = 8;
    localparam int PERIPH_DW = 16;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_GRANT0 = 2'd1;
    localparam logic [1:0] ARB_GRANT1 = 2'd2;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_DMA = 1'b1;

    // Grant target from IDLE; on contention the master that was not served last wins.
    function automatic logic [1:0] arb_pick(input logic req0, input logic req1, input logic last);
        logic [1:0] pick;
        case ({req0, req1})
            2'b10:   pick = ARB_GRANT0;
            2'b01:   pick = ARB_GRANT1;
            2'b11:   pick = (last == MASTER_DMA) ? ARB_GRANT0 : ARB_GRANT1;
            default: pick = ARB_IDLE;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/periph_bus_arbiter_timeout_ctr.sv
// GRANT-phase watchdog for periph_bus_arbiter: counts un-acked grant cycles and flags expiry.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module arb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TW             = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [TW-1:0] count_r;

    assign expired = (count_r == TW'(TIMEOUT_CYCLES - 1));

    // Cleared outside GRANT so every grant starts at zero; holds once expired.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {TW{1'b0}};
        end else if (clear) begin
            count_r <= {TW{1'b0}};
        end else if (count_en && !expired) begin
            count_r <= count_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral bus (M0 = cpu, M1 = dma), one transfer per grant.
// Optional GRANT timeout enabled by defining ARB_TIMEOUT_EN.
import periph_bus_arbiter_pkg::*;

module periph_bus_arbiter #(
    parameter int AW             = PERIPH_AW,
    parameter int DW             = PERIPH_DW,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          s_sel,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ack
);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       last_r;
    logic       last_nxt_s;
    logic       gnt0_s;
    logic       gnt1_s;
    logic       expire_s;
    logic       tmo0_s;
    logic       tmo1_s;

    assign gnt0_s = (state_r == ARB_GRANT0);
    assign gnt1_s = (state_r == ARB_GRANT1);

`ifdef ARB_TIMEOUT_EN
    arb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TW             (4)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst      (rst),
        .clear    (!(gnt0_s || gnt1_s)),
        .count_en ((gnt0_s || gnt1_s) && !s_ack),
        .expired  (expire_s)
    );

    // A slave ack in the expiry cycle wins; a withdrawn request aborts silently instead.
    assign tmo0_s = gnt0_s && expire_s && !s_ack && m0_req;
    assign tmo1_s = gnt1_s && expire_s && !s_ack && m1_req;
    assign m0_err = tmo0_s;
    assign m1_err = tmo1_s;
`else
    assign expire_s = 1'b0;
    assign tmo0_s   = expire_s;
    assign tmo1_s   = expire_s;
    assign m0_err   = 1'b0;
    assign m1_err   = 1'b0;
`endif

    // Next-state and last-granted tracking.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        case (state_r)
            ARB_IDLE: begin
                state_nxt_s = arb_pick(m0_req, m1_req, last_r);
            end
            ARB_GRANT0: begin
                if (s_ack || tmo0_s) begin
                    state_nxt_s = ARB_IDLE;
                    last_nxt_s  = MASTER_CPU;
                end else if (!m0_req) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_GRANT0;
                end
            end
            ARB_GRANT1: begin
                if (s_ack || tmo1_s) begin
                    state_nxt_s = ARB_IDLE;
                    last_nxt_s  = MASTER_DMA;
                end else if (!m1_req) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_GRANT1;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State registers; reset leaves M1 as last so M0 takes the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
            last_r  <= MASTER_DMA;
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Slave-side request mux; everything reads as zero while no grant is active.
    always_comb begin
        s_sel   = 1'b0;
        s_we    = 1'b0;
        s_addr  = {AW{1'b0}};
        s_wdata = {DW{1'b0}};
        if (gnt0_s) begin
            s_sel   = 1'b1;
            s_we    = m0_we;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
        end else if (gnt1_s) begin
            s_sel   = 1'b1;
            s_we    = m1_we;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end else begin
            s_sel   = 1'b0;
        end
    end

    // Master-side response demux; a timed-out transfer returns zero data.
    always_comb begin
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_rdata = {DW{1'b0}};
        m1_rdata = {DW{1'b0}};
        if (gnt0_s) begin
            m0_ack   = s_ack || tmo0_s;
            m0_rdata = tmo0_s ? {DW{1'b0}} : s_rdata;
        end else if (gnt1_s) begin
            m1_ack   = s_ack || tmo1_s;
            m1_rdata = tmo1_s ? {DW{1'b0}} : s_rdata;
        end else begin
            m0_ack   = 1'b0;
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: cycle vector table plus ack scoreboard.
module tb_periph_bus_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam logic [AW-1:0] M0_ADDR  = 8'h02;
    localparam logic [DW-1:0] M0_WDATA = 16'h1234;
    localparam logic [AW-1:0] M1_ADDR  = 8'h10;
    localparam logic [DW-1:0] M1_WDATA = 16'h5555;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_ack, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_ack, m1_err;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          s_sel, s_we, s_ack;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [15:0] rdata;
        logic        err;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic r0;
        logic r1;
        logic ack;
        int   grant;
        logic a0;
        logic a1;
    } vec_t;
    vec_t vecs[33];

    always #5 clk = ~clk;

    periph_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // grant: 0 = none, 1 = M0, 2 = M1
    task automatic check_bus(input string name, input int grant,
                             input logic a0, input logic a1, input logic e0, input logic e1);
        logic          sel_e, we_e;
        logic [AW-1:0] addr_e;
        logic [DW-1:0] wdata_e, rd0_e, rd1_e;
        sel_e   = (grant != 0);
        we_e    = (grant == 1);
        addr_e  = (grant == 1) ? M0_ADDR : ((grant == 2) ? M1_ADDR : 8'h00);
        wdata_e = (grant == 1) ? M0_WDATA : ((grant == 2) ? M1_WDATA : 16'h0000);
        rd0_e   = (grant == 1 && !e0) ? s_rdata : 16'h0000;
        rd1_e   = (grant == 2 && !e1) ? s_rdata : 16'h0000;
        check(name,
              {2'b00, s_sel, s_we, s_addr, s_wdata, m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata},
              {2'b00, sel_e, we_e, addr_e, wdata_e, a0, a1, e0, e1, rd0_e, rd1_e});
    endtask

    task automatic drive(input logic r0, input logic r1, input logic ack, input logic [15:0] rd);
        m0_req  = r0;
        m1_req  = r1;
        s_ack   = ack;
        s_rdata = rd;
    endtask

    task automatic push(input int id, input logic [15:0] rd, input logic err);
        sb_t e;
        e.id    = id;
        e.rdata = rd;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r0, input logic r1, input logic ack,
                                input int grant, input logic a0, input logic a1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.ack = ack; v.grant = grant; v.a0 = a0; v.a1 = a1;
        return v;
    endfunction

    // Scoreboard: every master ack must match the oldest expected completion.
    always @(negedge clk) begin
        sb_t e;
        if (m0_ack || m1_ack) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_ack", 64'({m0_ack, m1_ack}), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_ack_owner", 64'({m0_ack, m1_ack}), (e.id == 0) ? 64'd2 : 64'd1);
                check("sb_rdata", 64'((e.id == 0) ? m0_rdata : m1_rdata), 64'(e.rdata));
                check("sb_err", 64'((e.id == 0) ? m0_err : m1_err), 64'(e.err));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        for (int i = 10; i < 26; i++) begin
            if (i % 2 == 0)      vecs[i] = mk(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
            else if (i % 4 == 3) vecs[i] = mk(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0);
            else                 vecs[i] = mk(1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b1);
        end
        vecs[26] = mk(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        vecs[27] = mk(1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        vecs[28] = mk(1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        vecs[29] = mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        vecs[30] = mk(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        vecs[31] = mk(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0);
        vecs[32] = mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        m0_we = 1'b1; m0_addr = M0_ADDR; m0_wdata = M0_WDATA;
        m1_we = 1'b0; m1_addr = M1_ADDR; m1_wdata = M1_WDATA;

        // Reset held with both masters requesting.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 16'hAAAA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bus($sformatf("reset_hold%0d", i), 0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        check_bus("post_reset_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        check_bus("first_grant_m0", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check_bus("grant_before_rst_edge", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        // Cycle vector table.
        for (int i = 0; i < 33; i++) begin
            rd = (i == 7) ? 16'hBEEF : (16'hC000 + 16'(i));
            drive(vecs[i].r0, vecs[i].r1, vecs[i].ack, rd);
            if (vecs[i].a0) push(0, rd, 1'b0);
            if (vecs[i].a1) push(1, rd, 1'b0);
            @(negedge clk);
            check_bus($sformatf("vec%0d", i), vecs[i].grant, vecs[i].a0, vecs[i].a1, 1'b0, 1'b0);
            step();
        end

        // Reset during GRANT1 before any slave ack.
        drive(1'b0, 1'b1, 1'b0, 16'h1111);
        @(negedge clk);
        check_bus("rst_mid_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        check_bus("rst_mid_grant1", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check_bus("rst_mid_grant1_hold", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h2222);
        @(negedge clk);
        check_bus("rst_mid_dropped", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        check_bus("rst_mid_m0_wins", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Slave never acks M0.
`ifdef ARB_TIMEOUT_EN
        for (int k = 2; k <= 15; k++) begin
            if (k == 15) push(0, 16'h0000, 1'b1);
            @(negedge clk);
            check_bus($sformatf("tmo_cycle%0d", k), 1, (k == 15), 1'b0, (k == 15), 1'b0);
            step();
        end
`else
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            check_bus($sformatf("no_tmo_cycle%0d", k), 1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 1'b1, 16'h3333);
        push(0, 16'h3333, 1'b0);
        @(negedge clk);
        check_bus("no_tmo_late_ack", 1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
`endif
        drive(1'b0, 1'b1, 1'b0, 16'h4444);
        @(negedge clk);
        check_bus("after_m0_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b1, 16'h5A5A);
        push(1, 16'h5A5A, 1'b0);
        @(negedge clk);
        check_bus("m1_after_m0", 2, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check_bus("final_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
